// File: rtl/aes_ctrl_pkg.sv
// Shared constants and state encoding for the AES-128 round sequencer.
package aes_ctrl_pkg;

  localparam int NROUNDS = 10;
  localparam int NCOLS   = 4;
  localparam int ROUND_W = 4;
  localparam int COL_W   = 2;
  localparam int FLUSH_W = 4;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NROUNDS);
  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(NCOLS - 1);

  // Binary 3-bit state encoding of the sequencer.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/aes_ctrl_cnt.sv
// Up-counter with synchronous clear, enable and terminal-count flag.
module aes_ctrl_cnt #(
  parameter int unsigned    W  = 4,
  parameter logic [W-1:0]   TC = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         tc
);

  logic [W-1:0] q_r;

  // Count register: reset and clear force zero, clear has priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= '0;
    end else if (clr) begin
      q_r <= '0;
    end else if (en) begin
      q_r <= q_r + W'(1'b1);
    end else begin
      q_r <= q_r;
    end
  end

  assign q  = q_r;
  assign tc = (q_r == TC);

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the 32-bit-serial masked AES-128 core: LOAD, ten
// ROUND/FLUSH passes, then DONE with a ready/valid result handshake.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned SBOX_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               load_en,
  output logic               sbox_en,
  output logic [COL_W-1:0]   col,
  output logic [ROUND_W-1:0] round,
  output logic               last_round,
  output logic               rcon_init,
  output logic               rcon_update,
  output logic               rcon_mask
);

  // Terminal flush count and the count one cycle before it.
  localparam logic [FLUSH_W-1:0] FLUSH_TC     = FLUSH_W'(SBOX_LAT - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_PRE    = FLUSH_W'((SBOX_LAT >= 2) ? (SBOX_LAT - 2) : 0);
  localparam bit                 SINGLE_FLUSH = (SBOX_LAT == 1);

  state_e               state_r;
  state_e               state_nx_s;
  logic                 accept_s;
  logic                 last_flush_nx_s;

  logic [COL_W-1:0]     col_q_s;
  logic                 col_tc_s;
  logic                 col_clr_s;
  logic                 col_en_s;
  logic [ROUND_W-1:0]   round_q_s;
  logic                 round_tc_s;
  logic                 round_clr_s;
  logic                 round_en_s;
  logic [FLUSH_W-1:0]   flush_q_s;
  logic                 flush_tc_s;
  logic                 flush_clr_s;
  logic                 flush_en_s;

  logic                 load_en_r;
  logic                 sbox_en_r;
  logic                 busy_r;
  logic                 out_valid_r;
  logic                 rcon_update_r;
  logic                 rcon_mask_r;

  aes_ctrl_cnt #(.W(COL_W), .TC(LAST_COL)) u_col_cnt (
    .clk (clk),
    .rst (rst),
    .clr (col_clr_s),
    .en  (col_en_s),
    .q   (col_q_s),
    .tc  (col_tc_s)
  );

  aes_ctrl_cnt #(.W(ROUND_W), .TC(LAST_ROUND)) u_round_cnt (
    .clk (clk),
    .rst (rst),
    .clr (round_clr_s),
    .en  (round_en_s),
    .q   (round_q_s),
    .tc  (round_tc_s)
  );

  aes_ctrl_cnt #(.W(FLUSH_W), .TC(FLUSH_TC)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (flush_clr_s),
    .en  (flush_en_s),
    .q   (flush_q_s),
    .tc  (flush_tc_s)
  );

  assign in_ready = (state_r == ST_IDLE);
  assign accept_s = in_valid & in_ready;

  // Next-state selection; in_valid is only looked at in IDLE.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_nx_s = ST_LOAD;
        else          state_nx_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (col_tc_s) state_nx_s = ST_ROUND;
        else          state_nx_s = ST_LOAD;
      end
      ST_ROUND: begin
        if (col_tc_s) state_nx_s = ST_FLUSH;
        else          state_nx_s = ST_ROUND;
      end
      ST_FLUSH: begin
        if (flush_tc_s && round_tc_s)  state_nx_s = ST_DONE;
        else if (flush_tc_s)           state_nx_s = ST_ROUND;
        else                           state_nx_s = ST_FLUSH;
      end
      ST_DONE: begin
        if (out_ready) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Counter controls: col walks only in LOAD/ROUND and is cleared at its end,
  // round steps on entry to round 1 and after each non-final flush.
  always_comb begin
    col_clr_s   = 1'b1;
    col_en_s    = 1'b0;
    round_clr_s = (state_nx_s == ST_IDLE);
    round_en_s  = ((state_r == ST_LOAD) && col_tc_s) ||
                  ((state_r == ST_FLUSH) && flush_tc_s && !round_tc_s);
    flush_clr_s = (state_r != ST_FLUSH);
    flush_en_s  = (state_r == ST_FLUSH) && !flush_tc_s;
    if (((state_r == ST_LOAD) || (state_r == ST_ROUND)) && !col_tc_s) begin
      col_clr_s = 1'b0;
      col_en_s  = 1'b1;
    end else begin
      col_clr_s = 1'b1;
      col_en_s  = 1'b0;
    end
  end

  // Predict whether the coming cycle is the final flush cycle.
  always_comb begin
    last_flush_nx_s = 1'b0;
    if (state_nx_s == ST_FLUSH) begin
      if (state_r == ST_FLUSH) last_flush_nx_s = (flush_q_s == FLUSH_PRE);
      else                     last_flush_nx_s = SINGLE_FLUSH;
    end else begin
      last_flush_nx_s = 1'b0;
    end
  end

  // State and registered output decode, computed from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      load_en_r     <= 1'b0;
      sbox_en_r     <= 1'b0;
      busy_r        <= 1'b0;
      out_valid_r   <= 1'b0;
      rcon_update_r <= 1'b0;
      rcon_mask_r   <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      load_en_r     <= (state_nx_s == ST_LOAD);
      sbox_en_r     <= (state_nx_s == ST_ROUND);
      busy_r        <= (state_nx_s != ST_IDLE);
      out_valid_r   <= (state_nx_s == ST_DONE);
      rcon_update_r <= last_flush_nx_s && !round_tc_s;
      rcon_mask_r   <= (state_nx_s == ST_ROUND) && (state_r != ST_ROUND);
    end
  end

  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign load_en     = load_en_r;
  assign sbox_en     = sbox_en_r;
  assign col         = col_q_s;
  assign round       = round_q_s;
  assign last_round  = round_tc_s;
  assign rcon_mask   = rcon_mask_r;
  // Reset forces the rcon generator back to 0x01 and suppresses any update.
  assign rcon_init   = rst | accept_s;
  assign rcon_update = rcon_update_r & ~rst;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: three instances (SBOX_LAT 4, 1, 15),
// latency scoreboard and a shadow rcon generator.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_a    [3];
  logic       out_ready_a   [3];
  logic       in_ready_a    [3];
  logic       out_valid_a   [3];
  logic       busy_a        [3];
  logic       load_en_a     [3];
  logic       sbox_en_a     [3];
  logic [1:0] col_a         [3];
  logic [3:0] round_a       [3];
  logic       last_round_a  [3];
  logic       rcon_init_a   [3];
  logic       rcon_update_a [3];
  logic       rcon_mask_a   [3];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_round_ctrl #(.SBOX_LAT((g == 0) ? 4 : ((g == 1) ? 1 : 15))) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid_a[g]),
      .in_ready    (in_ready_a[g]),
      .out_valid   (out_valid_a[g]),
      .out_ready   (out_ready_a[g]),
      .busy        (busy_a[g]),
      .load_en     (load_en_a[g]),
      .sbox_en     (sbox_en_a[g]),
      .col         (col_a[g]),
      .round       (round_a[g]),
      .last_round  (last_round_a[g]),
      .rcon_init   (rcon_init_a[g]),
      .rcon_update (rcon_update_a[g]),
      .rcon_mask   (rcon_mask_a[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon_exp(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // One encryption on instance idx, started from an IDLE negedge.
  task automatic run_enc(input int idx, input int lat, input bit keep_valid, input int bp);
    int         t;
    int         n_load;
    int         n_sbox;
    int         n_upd;
    int         n_mask;
    int         exp_cyc;
    bit         done;
    logic [7:0] shadow;
    t = 0; n_load = 0; n_sbox = 0; n_upd = 0; n_mask = 0; done = 1'b0;
    shadow = 8'h01;
    chk("start_in_ready", 32'(in_ready_a[idx]), 32'd1);
    in_valid_a[idx] = 1'b1;
    #1;
    chk("accept_rcon_init", 32'(rcon_init_a[idx]), 32'd1);
    exp_q.push_back(cyc + 5 + 10 * (4 + lat));
    while (!done && t < 400) begin
      @(negedge clk);
      t++;
      if (!keep_valid) in_valid_a[idx] = 1'b0;
      chk("busy_vs_ready", 32'(busy_a[idx]), 32'(!in_ready_a[idx]));
      chk("upd_init_excl", 32'(rcon_update_a[idx] & rcon_init_a[idx]), 32'd0);
      chk("last_round", 32'(last_round_a[idx]), 32'(round_a[idx] == 4'd10));
      if (load_en_a[idx]) begin
        n_load++;
        chk("load_cycle", 32'(t), 32'(n_load));
        chk("load_col", 32'(col_a[idx]), 32'(n_load - 1));
        chk("load_round", 32'(round_a[idx]), 32'd0);
      end
      if (sbox_en_a[idx]) n_sbox++;
      if (rcon_mask_a[idx]) begin
        n_mask++;
        chk("mask_col", 32'(col_a[idx]), 32'd0);
        chk("mask_round", 32'(round_a[idx]), 32'(n_mask));
        chk("mask_rcon", 32'(shadow), 32'(rcon_exp(round_a[idx])));
      end
      if (rcon_update_a[idx]) begin
        n_upd++;
        shadow = xtime(shadow);
      end
      if (out_valid_a[idx]) begin
        done = 1'b1;
        chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
          exp_cyc = exp_q.pop_front();
          chk("out_latency", 32'(cyc), 32'(exp_cyc));
        end
      end
    end
    chk("no_timeout", 32'(done), 32'd1);
    chk("load_count", 32'(n_load), 32'd4);
    chk("sbox_count", 32'(n_sbox), 32'd40);
    chk("upd_count", 32'(n_upd), 32'd9);
    chk("mask_count", 32'(n_mask), 32'd10);
    chk("rcon_final", 32'(shadow), 32'h36);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid_a[idx]), 32'd1);
      chk("bp_busy", 32'(busy_a[idx]), 32'd1);
      chk("bp_in_ready", 32'(in_ready_a[idx]), 32'd0);
    end
    out_ready_a[idx] = 1'b1;
    @(negedge clk);
    out_ready_a[idx] = 1'b0;
    chk("exit_in_ready", 32'(in_ready_a[idx]), 32'd1);
    chk("exit_busy", 32'(busy_a[idx]), 32'd0);
    chk("exit_out_valid", 32'(out_valid_a[idx]), 32'd0);
    chk("exit_round", 32'(round_a[idx]), 32'd0);
    chk("exit_col", 32'(col_a[idx]), 32'd0);
    chk("exit_no_load", 32'(load_en_a[idx]), 32'd0);
  endtask

  initial begin
    int t;
    bit found;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid_a[i]  = 1'b0;
      out_ready_a[i] = 1'b0;
    end

    // Reset held for three cycles, out_ready pulsed with no out_valid.
    repeat (3) begin
      @(negedge clk);
      chk("rst_rcon_init", 32'(rcon_init_a[0]), 32'd1);
    end
    chk("rst_in_ready", 32'(in_ready_a[0]), 32'd1);
    chk("rst_busy", 32'(busy_a[0]), 32'd0);
    chk("rst_round", 32'(round_a[0]), 32'd0);
    chk("rst_col", 32'(col_a[0]), 32'd0);
    chk("rst_strobes", 32'({load_en_a[0], sbox_en_a[0], rcon_update_a[0], rcon_mask_a[0], out_valid_a[0]}), 32'd0);
    rst = 1'b0;
    out_ready_a[0] = 1'b1;
    #1;
    chk("idle_rcon_init", 32'(rcon_init_a[0]), 32'd0);
    @(negedge clk);
    out_ready_a[0] = 1'b0;
    chk("stray_ready_idle", 32'(in_ready_a[0]), 32'd1);
    chk("stray_ready_busy", 32'(busy_a[0]), 32'd0);
    chk("idle_ready_lat1", 32'(in_ready_a[1]), 32'd1);
    chk("idle_ready_lat15", 32'(in_ready_a[2]), 32'd1);

    // Single encryption with 7 cycles of back-pressure.
    run_enc(0, 4, 1'b0, 7);

    // Reset in the last flush cycle of round 5.
    in_valid_a[0] = 1'b1;
    t = 0;
    found = 1'b0;
    while (!found && t < 200) begin
      @(negedge clk);
      in_valid_a[0] = 1'b0;
      t++;
      if (round_a[0] == 4'd5 && rcon_update_a[0]) found = 1'b1;
    end
    chk("midrst_reached", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_no_update", 32'(rcon_update_a[0]), 32'd0);
    chk("midrst_rcon_init", 32'(rcon_init_a[0]), 32'd1);
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready_a[0]), 32'd1);
    chk("midrst_busy", 32'(busy_a[0]), 32'd0);
    chk("midrst_round", 32'(round_a[0]), 32'd0);
    chk("midrst_no_update2", 32'(rcon_update_a[0]), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_enc(0, 4, 1'b0, 0);

    // in_valid held high: second accept only after the output handshake.
    run_enc(0, 4, 1'b1, 2);
    run_enc(0, 4, 1'b0, 0);

    // Latency sweep on the other instances.
    run_enc(1, 1, 1'b0, 0);
    run_enc(2, 15, 1'b0, 1);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Top-level sequencer for the 32-bit-serial masked AES-128 encryption core. It accepts a start handshake and steps the datapath through a load phase and ten rounds, each of four column cycles plus an S-box pipeline flush. It drives the round-constant generator (update, output gate, re-init), the column and round indices, and the MixColumns bypass. It returns a result handshake when the encryption is complete.

Parameters:
SBOX_LAT, 4, masked S-box pipeline latency in cycles; legal range 1..15.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  start request; plaintext and key columns are presented during LOAD
in_ready  out  1  high only in IDLE
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts ciphertext
busy  out  1  high in every state except IDLE
load_en  out  1  datapath captures the input column indexed by col
sbox_en  out  1  datapath feeds column col into the S-box
col  out  2  current column index
round  out  4  current round, 0 during LOAD, 1..10 in rounds
last_round  out  1  round==10; datapath bypasses MixColumns
rcon_init  out  1  forces the rcon generator to 0x01
rcon_update  out  1  advances the rcon generator
rcon_mask  out  1  gates rcon into the key path

Behaviour:
- Reset: state=IDLE, col=0, round=0, flush counter=0, out_valid=0. All strobes (load_en, sbox_en, rcon_update, rcon_mask) are 0. rcon_init=1 while rst is high (rcon_init = rst OR accept).
- States: IDLE, LOAD, ROUND, FLUSH, DONE. Every output is a registered state decode except in_ready and rcon_init.
- IDLE: in_ready=1. Accept = in_valid & in_ready. The accept cycle pulses rcon_init; the next state is LOAD with col=0.
- LOAD: load_en=1 for 4 cycles, col 0,1,2,3. After col 3 the next state is ROUND with round=1, col=0.
- ROUND: sbox_en=1 for 4 cycles, col 0..3. rcon_mask=1 only when col==0 (first key word of the round); 0 otherwise. After col 3 the next state is FLUSH and the flush counter clears.
- FLUSH: sbox_en=0 for SBOX_LAT cycles. On the last flush cycle:
  - rcon_update=1 iff round<10; this yields 0x01,0x02,…,0x80,0x1b,0x36 for rounds 1..10.
  - If round==10, the next state is DONE.
  - Otherwise round increments and the next state is ROUND with col=0.
- last_round is combinational from round==10 and is valid through ROUND and FLUSH of round 10.
- DONE: out_valid=1 and is held until out_ready. When out_valid & out_ready, the next state is IDLE with round=0 and col=0. No new accept occurs in that same cycle.
- Latency: accept at cycle T0 gives out_valid first high at T0 + 5 + 10*(4+SBOX_LAT); 85 cycles for the default.
- Boundary conditions:
  - in_valid outside IDLE is ignored.
  - out_ready without out_valid is ignored.
  - rst mid-operation returns to the reset values on the next edge and discards the encryption. rst wins over every other event.
  - The round counter never exceeds 10.
  - The col and flush counters wrap only under FSM control.
  - rcon_update and rcon_init are never high in the same cycle.

Decomposition:
- Shared package (aes_ctrl_pkg) holds:
  - NROUNDS=10, NCOLS=4
  - the state encoding (localparams, binary 3-bit)
  - the widths of round and col
- One sub-module is natural: aes_ctrl_cnt, a parameterised-width counter with sync clear, enable and terminal-count flag. It is instantiated for col, round and flush.

Test Plan:
- Reset then idle: rst held 3 cycles. Expect in_ready=1, busy=0, round=0, all strobes 0, rcon_init=1 only during rst.
- Single encryption, SBOX_LAT=4, in_valid pulse at T0:
  - load_en high T1..T4.
  - out_valid rises at T85.
  - rcon_update pulses exactly 9 times.
  - rcon_mask pulses exactly 10 times, each at col==0.
  - A shadow rcon model reads 0x36 in round 10.
- Back-pressure: out_ready low for 7 cycles after out_valid. Expect out_valid held, busy=1, in_ready=0. With out_ready=1, the state returns to IDLE next cycle.
- Mid-operation reset: assert rst at round 5, FLUSH. Expect IDLE next cycle with round=0 and no rcon_update. A new start then completes in 85 cycles with correct rcon sequence.
- Ignored start: in_valid held high continuously. Expect the second accept only one cycle after the out handshake, i.e. in_ready=1 in the cycle after DONE exits.
- Parameter sweep SBOX_LAT=1 and 15: out_valid at T0+55 and T0+195 respectively. last_round high only during round 10.
